arb_requester: RTL and testbench

Client-side agent for the four-way priority arbiter: owns one `arb_reqN`/`arb_gntN` pair.
- Queues burst commands from local logic in a small FIFO.
- Raises the request, waits for the grant, then drives a burst of incrementing data beats onto the shared bus while it holds the grant.
- Releases the request after the last beat and holds an idle gap before re-requesting.

---
 rtl/arb_requester_if.sv | 38 +++
 rtl/arb_requester.sv | 221 ++++++++++++++++++++++
 tb/tb_arb_requester.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_requester_if.sv
// -----------------------------------------------------------------------------
// arb_requester_if
// Bundles the command, arbiter-handshake and shared-bus signals of one
// arbiter client.
//   master : the requester agent (accepts commands, drives req/bus/status)
//   slave  : the surrounding logic (offers commands, returns grant, observes bus)
// Signals:
//   cmd_valid/cmd_ready/cmd_len/cmd_data : command push handshake
//   arb_req/arb_gnt                      : request/grant pair to the arbiter
//   bus_valid/bus_data/bus_last          : burst beats on the shared bus
//   busy, timeout_err                    : status
// -----------------------------------------------------------------------------
interface arb_requester_if #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              arb_req;
    logic              arb_gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  cmd_valid, cmd_len, cmd_data, arb_gnt,
        output cmd_ready, arb_req, bus_valid, bus_data, bus_last, busy, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_data, arb_gnt,
        input  cmd_ready, arb_req, bus_valid, bus_data, bus_last, busy, timeout_err
    );
endinterface

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Client agent for a four-way priority arbiter. Commands {len, first data}
// are queued in a small FIFO; for each one the agent raises arb_req, waits
// for arb_gnt, then emits len+1 incrementing beats while it holds the grant,
// releases the request and idles for GAP cycles before the next request.
// Ports:
//   arb_clk, arb_rst : clock (rising edge), asynchronous active-high reset
//   bus (master)     : command push, arbiter req/gnt, bus beats, status
// Optional feature: define ARB_REQ_TIMEOUT_EN to abandon a request after
// TIMEOUT grant-less REQ cycles (timeout_err pulses, command discarded).
// Without it REQ waits forever and timeout_err is tied low.
// -----------------------------------------------------------------------------
module arb_requester #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4,
    parameter int DATA_W     = 8,
    parameter int GAP        = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic            arb_clk,
    input  logic            arb_rst,
    arb_requester_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // command FIFO
    logic [LEN_W+DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    cmd_ready_s;
    logic                    push_s;
    logic                    pop_s;

    // burst engine
    state_t            state_r, state_nxt_s;
    logic              arb_req_r, arb_req_nxt_s;
    logic              bus_valid_r, bus_valid_nxt_s;
    logic [LEN_W-1:0]  beat_r, beat_nxt_s;
    logic [LEN_W-1:0]  len_r, len_nxt_s;
    logic [DATA_W-1:0] base_r, base_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
    logic            tmo_err_r, tmo_err_nxt_s;
`else
    logic [31:0]     unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
`endif

    // Ready comes from the registered count so it never depends on this cycle's pop.
    assign cmd_ready_s = (count_r != CNT_W'(FIFO_DEPTH));
    assign push_s      = bus.cmd_valid && cmd_ready_s;

    // FIFO storage; payload only, validity tracked by count_r
    always_ff @(posedge arb_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_len, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM next-state and registered-output computation
    always_comb begin
        state_nxt_s     = state_r;
        arb_req_nxt_s   = arb_req_r;
        bus_valid_nxt_s = bus_valid_r;
        beat_nxt_s      = beat_r;
        len_nxt_s       = len_r;
        base_nxt_s      = base_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        pop_s           = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        to_cnt_nxt_s    = to_cnt_r;
        tmo_err_nxt_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    pop_s                   = 1'b1;
                    {len_nxt_s, base_nxt_s} = mem_r[rd_ptr_r];
                    beat_nxt_s              = LEN_W'(0);
                    arb_req_nxt_s           = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
                    to_cnt_nxt_s            = TO_W'(0);
`endif
                    state_nxt_s             = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A grant seen on the expiry edge still wins.
                if (bus.arb_gnt) begin
                    bus_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_OWN;
                end else begin
`ifdef ARB_REQ_TIMEOUT_EN
                    if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                        arb_req_nxt_s = 1'b0;
                        tmo_err_nxt_s = 1'b1;
                        gap_cnt_nxt_s = GAP_W'(0);
                        state_nxt_s   = ST_GAP;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + TO_W'(1);
                    end
`else
                    state_nxt_s = ST_REQ;
`endif
                end
            end
            ST_OWN: begin
                // A beat is consumed on every edge where bus_valid is high;
                // a dropped grant stalls the burst without losing the beat index.
                if (bus_valid_r) begin
                    if (beat_r == len_r) begin
                        arb_req_nxt_s   = 1'b0;
                        bus_valid_nxt_s = 1'b0;
                        gap_cnt_nxt_s   = GAP_W'(0);
                        state_nxt_s     = ST_GAP;
                    end else begin
                        beat_nxt_s      = beat_r + LEN_W'(1);
                        bus_valid_nxt_s = bus.arb_gnt;
                    end
                end else begin
                    bus_valid_nxt_s = bus.arb_gnt;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(GAP - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                arb_req_nxt_s   = 1'b0;
                bus_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state and burst registers
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            state_r     <= ST_IDLE;
            arb_req_r   <= 1'b0;
            bus_valid_r <= 1'b0;
            beat_r      <= LEN_W'(0);
            len_r       <= LEN_W'(0);
            base_r      <= DATA_W'(0);
            gap_cnt_r   <= GAP_W'(0);
        end else begin
            state_r     <= state_nxt_s;
            arb_req_r   <= arb_req_nxt_s;
            bus_valid_r <= bus_valid_nxt_s;
            beat_r      <= beat_nxt_s;
            len_r       <= len_nxt_s;
            base_r      <= base_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    // grant-wait counter and abandonment pulse
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            to_cnt_r  <= TO_W'(0);
            tmo_err_r <= 1'b0;
        end else begin
            to_cnt_r  <= to_cnt_nxt_s;
            tmo_err_r <= tmo_err_nxt_s;
        end
    end
    assign bus.timeout_err = tmo_err_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.arb_req   = arb_req_r;
    assign bus.bus_valid = bus_valid_r;
    // Payload wraps modulo 2^DATA_W; it is zero out of reset since base and beat are.
    assign bus.bus_data  = base_r + DATA_W'(beat_r);
    assign bus.bus_last  = bus_valid_r && (beat_r == len_r);
    assign bus.busy      = (state_r != ST_IDLE) || (count_r != CNT_W'(0));

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 8;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 16;

    logic arb_clk = 1'b0;
    logic arb_rst = 1'b1;
    always #5 arb_clk = ~arb_clk;

    arb_requester_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bif ();

    arb_requester #(
        .FIFO_DEPTH(4), .LEN_W(LEN_W), .DATA_W(DATA_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .arb_clk(arb_clk),
        .arb_rst(arb_rst),
        .bus    (bif)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0] len;
        logic [7:0] data;
        int         beats;
        logic [7:0] last;
    } vec_t;

    beat_t      exp_q[$];
    beat_t      nb;
    beat_t      eb;
    int         n_checks   = 0;
    int         n_errors   = 0;
    int         beats_seen = 0;
    logic [7:0] last_data  = 8'h00;
    bit         sb_en      = 1'b1;
    vec_t       vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: queue expected beats at accept, compare when beats appear
    always @(negedge arb_clk) begin
        if (!arb_rst) begin
            if (sb_en && bif.cmd_valid && bif.cmd_ready) begin
                for (int i = 0; i <= int'(bif.cmd_len); i++) begin
                    nb.data = bif.cmd_data + 8'(i);
                    nb.last = (i == int'(bif.cmd_len));
                    exp_q.push_back(nb);
                end
            end
            if (bif.bus_valid) begin
                beats_seen++;
                if (bif.bus_last) last_data = bif.bus_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("beat_data", 32'(bif.bus_data), 32'(eb.data));
                    chk("beat_last", 32'(bif.bus_last), 32'(eb.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] len, input logic [7:0] data);
        int k = 0;
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = len;
        bif.cmd_data  = data;
        while (!bif.cmd_ready && k < 200) begin
            step();
            k++;
        end
        chk("push_accept", 32'(k < 200), 32'd1);
        step();
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((bif.busy || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("drain", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_beat(input logic [7:0] data);
        int k = 0;
        while (!(bif.bus_valid && bif.bus_data == data) && k < 100) begin
            step();
            k++;
        end
        chk("wait_beat", 32'(k < 100), 32'd1);
    endtask

    initial begin
        vecs[0] = '{len: 4'd3,  data: 8'h10, beats: 4,  last: 8'h13};
        vecs[1] = '{len: 4'd1,  data: 8'hFF, beats: 2,  last: 8'h00};
        vecs[2] = '{len: 4'd0,  data: 8'h5A, beats: 1,  last: 8'h5A};
        vecs[3] = '{len: 4'd15, data: 8'hF8, beats: 16, last: 8'h07};

        bif.cmd_valid = 1'b0;
        bif.cmd_len   = 4'd0;
        bif.cmd_data  = 8'h00;
        bif.arb_gnt   = 1'b0;
        arb_rst       = 1'b1;
        step();
        step();
        // reset state
        chk("rst_req",   32'(bif.arb_req),     32'd0);
        chk("rst_valid", 32'(bif.bus_valid),   32'd0);
        chk("rst_last",  32'(bif.bus_last),    32'd0);
        chk("rst_busy",  32'(bif.busy),        32'd0);
        chk("rst_tmo",   32'(bif.timeout_err), 32'd0);
        chk("rst_data",  32'(bif.bus_data),    32'd0);
        chk("rst_ready", 32'(bif.cmd_ready),   32'd1);
        arb_rst = 1'b0;
        step();

        // cycle-exact single burst, grant tied high
        bif.arb_gnt   = 1'b1;
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = 4'd3;
        bif.cmd_data  = 8'h10;
        step();
        bif.cmd_valid = 1'b0;
        chk("a_req_t0",   32'(bif.arb_req),   32'd0);
        chk("a_busy_t0",  32'(bif.busy),      32'd1);
        step();
        chk("a_req_t1",   32'(bif.arb_req),   32'd1);
        chk("a_valid_t1", 32'(bif.bus_valid), 32'd0);
        step();
        chk("a_valid_t2", 32'(bif.bus_valid), 32'd1);
        chk("a_data_t2",  32'(bif.bus_data),  32'h10);
        chk("a_last_t2",  32'(bif.bus_last),  32'd0);
        step();
        step();
        step();
        chk("a_data_t5",  32'(bif.bus_data),  32'h13);
        chk("a_last_t5",  32'(bif.bus_last),  32'd1);
        chk("a_req_t5",   32'(bif.arb_req),   32'd1);
        step();
        chk("a_req_t6",   32'(bif.arb_req),   32'd0);
        chk("a_valid_t6", 32'(bif.bus_valid), 32'd0);
        chk("a_busy_t6",  32'(bif.busy),      32'd1);
        chk("a_tmo_t6",   32'(bif.timeout_err), 32'd0);
        step();
        chk("a_busy_t7",  32'(bif.busy),      32'd0);

        // table-driven bursts with grant held high
        for (int v = 0; v < 4; v++) begin
            beats_seen = 0;
            last_data  = 8'hAA;
            push_cmd(vecs[v].len, vecs[v].data);
            wait_idle(200);
            chk("tbl_beats", 32'(beats_seen), 32'(vecs[v].beats));
            chk("tbl_last",  32'(last_data),  32'(vecs[v].last));
        end

        // grant dropped for two cycles mid-burst
        push_cmd(4'd3, 8'h10);
        wait_beat(8'h11);
        bif.arb_gnt = 1'b0;
        step();
        chk("b_valid_d1", 32'(bif.bus_valid), 32'd0);
        chk("b_req_d1",   32'(bif.arb_req),   32'd1);
        step();
        chk("b_valid_d2", 32'(bif.bus_valid), 32'd0);
        chk("b_req_d2",   32'(bif.arb_req),   32'd1);
        bif.arb_gnt = 1'b1;
        step();
        chk("b_valid_r",  32'(bif.bus_valid), 32'd1);
        chk("b_data_r",   32'(bif.bus_data),  32'h12);
        step();
        chk("b_data_l",   32'(bif.bus_data),  32'h13);
        chk("b_last_l",   32'(bif.bus_last),  32'd1);
        wait_idle(100);

        // FIFO full: one command sits in REQ, four fill the FIFO
        bif.arb_gnt   = 1'b0;
        bif.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bif.cmd_len  = 4'(i % 2);
            bif.cmd_data = 8'(8'h40 + 8'(i * 16));
            chk("c_ready_pre", 32'(bif.cmd_ready), 32'd1);
            step();
        end
        bif.cmd_len  = 4'd2;
        bif.cmd_data = 8'hE0;
        for (int i = 0; i < 3; i++) begin
            chk("c_ready_full", 32'(bif.cmd_ready), 32'd0);
            chk("c_req_hold",   32'(bif.arb_req),   32'd1);
            chk("c_no_beat",    32'(bif.bus_valid), 32'd0);
            step();
        end
        bif.arb_gnt = 1'b1;
        begin
            int k = 0;
            while (!bif.cmd_ready && k < 50) begin
                step();
                k++;
            end
            chk("c_ready_ret", 32'(k < 50), 32'd1);
        end
        step();
        bif.cmd_valid = 1'b0;
        wait_idle(400);

        // reset mid-burst on beat 2 of len=7
        push_cmd(4'd7, 8'h20);
        wait_beat(8'h22);
        arb_rst = 1'b1;
        #1;
        chk("e_req",   32'(bif.arb_req),   32'd0);
        chk("e_valid", 32'(bif.bus_valid), 32'd0);
        chk("e_busy",  32'(bif.busy),      32'd0);
        chk("e_ready", 32'(bif.cmd_ready), 32'd1);
        chk("e_last",  32'(bif.bus_last),  32'd0);
        chk("e_data",  32'(bif.bus_data),  32'd0);
        step();
        step();
        exp_q.delete();
        arb_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("e_quiet_valid", 32'(bif.bus_valid), 32'd0);
            chk("e_quiet_req",   32'(bif.arb_req),   32'd0);
        end
        beats_seen = 0;
        push_cmd(4'd0, 8'h77);
        wait_idle(100);
        chk("e_recover", 32'(beats_seen), 32'd1);

`ifdef ARB_REQ_TIMEOUT_EN
        // request abandoned after TIMEOUT grant-less cycles
        begin
            int k  = 0;
            int hi = 0;
            int lo = 0;
            int tp = 0;
            sb_en       = 1'b0;
            bif.arb_gnt = 1'b0;
            push_cmd(4'd0, 8'h01);
            push_cmd(4'd0, 8'h02);
            while (!bif.arb_req && k < 50) begin
                step();
                k++;
            end
            if (bif.arb_req && hi == 0) begin
                while (bif.arb_req && hi < 100) begin
                    step();
                    hi++;
                    if (bif.timeout_err) tp++;
                end
            end
            step();
            lo = 1;
            if (bif.timeout_err) tp++;
            while (!bif.arb_req && lo < 100) begin
                step();
                lo++;
            end
            chk("t_req_cycles", 32'(hi), 32'(TIMEOUT));
            chk("t_err_pulse",  32'(tp), 32'd1);
            chk("t_gap",        32'(lo), 32'(GAP + 1));
            arb_rst = 1'b1;
            step();
            exp_q.delete();
            arb_rst = 1'b0;
            sb_en   = 1'b1;
            step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
